// File: rtl/divmmc_spi.sv
// DivMMC SPI master: Z80 port strobes become 8-bit mode-0 SPI exchanges, MSB first.
// Latency 16*DIV cycles from strobe to q; start strobes while busy are dropped, csW always applies.
module divmmc_spi #(
    parameter int DIV = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic       csW,
    input  logic       txW,
    input  logic       rxR,
    output logic [7:0] q,
    output logic       busy,
    output logic       sdcCs,
    output logic       sdcCk,
    output logic       sdcMosi,
    input  logic       sdcMiso
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(DIV - 1);

    state_t     r_state;
    logic [7:0] r_half;
    logic [2:0] r_bit;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_q;
    logic       r_busy;
    logic       r_cs;
    logic       r_ck;
    logic       r_mosi;

    logic       w_start;
    logic [7:0] w_tx_byte;
    logic       w_half_done;

    // txW takes priority; a read strobe clocks out all-ones to fetch the next byte
    assign w_start     = txW | rxR;
    assign w_tx_byte   = txW ? d : 8'hFF;
    assign w_half_done = (r_half == HALF_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_half  <= 8'd0;
            r_bit   <= 3'd0;
            r_tx    <= 8'hFF;
            r_rx    <= 8'hFF;
            r_q     <= 8'hFF;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
            r_ck    <= 1'b0;
            r_mosi  <= 1'b1;
        end else begin
            if (csW) begin
                r_cs <= d[0];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_LO;
                        r_tx    <= w_tx_byte;
                        r_mosi  <= w_tx_byte[7];
                        r_bit   <= 3'd0;
                        r_half  <= 8'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LO: begin
                    if (w_half_done) begin
                        r_half  <= 8'd0;
                        r_ck    <= 1'b1;
                        r_rx    <= {r_rx[6:0], sdcMiso};
                        r_state <= S_HI;
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                S_HI: begin
                    if (w_half_done) begin
                        r_half <= 8'd0;
                        r_ck   <= 1'b0;
                        if (r_bit != 3'd7) begin
                            r_tx    <= {r_tx[6:0], 1'b1};
                            r_mosi  <= r_tx[6];
                            r_bit   <= r_bit + 3'd1;
                            r_state <= S_LO;
                        end else begin
                            r_mosi  <= 1'b1;
                            r_q     <= r_rx;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign q       = r_q;
    assign busy    = r_busy;
    assign sdcCs   = r_cs;
    assign sdcCk   = r_ck;
    assign sdcMosi = r_mosi;

endmodule

// File: tb/tb_divmmc_spi.sv
// Scoreboard bench for divmmc_spi: DIV=2 and DIV=1 instances, expected exchanges queued at stimulus time.
module tb_divmmc_spi;

    typedef struct {
        logic [7:0] q;
        logic [7:0] mosi;
        int         cycles;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d = 8'h00;
    logic       csW = 1'b0;
    logic       txW0 = 1'b0, rxR0 = 1'b0, txW1 = 1'b0, rxR1 = 1'b0;
    logic       loop0 = 1'b1;
    logic       miso_val = 1'b0;

    logic [7:0] q0, q1;
    logic       busy0, busy1, cs0, cs1, ck0, ck1, mosi0, mosi1;
    logic       miso0, miso1;

    assign miso0 = loop0 ? mosi0 : miso_val;
    assign miso1 = mosi1;

    divmmc_spi #(.DIV(2)) u_dut0 (
        .clock(clock), .reset(reset), .d(d), .csW(csW), .txW(txW0), .rxR(rxR0),
        .q(q0), .busy(busy0), .sdcCs(cs0), .sdcCk(ck0), .sdcMosi(mosi0), .sdcMiso(miso0)
    );

    divmmc_spi #(.DIV(1)) u_dut1 (
        .clock(clock), .reset(reset), .d(d), .csW(csW), .txW(txW1), .rxR(rxR1),
        .q(q1), .busy(busy1), .sdcCs(cs1), .sdcCk(ck1), .sdcMosi(mosi1), .sdcMiso(miso1)
    );

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on every busy fall, pop the expected exchange and compare q, MOSI bits, edges, duration
    int         cnt_busy[2], nrise[2], viol[2];
    logic [7:0] msh[2];
    logic       pb[2], pck[2], pmosi[2];

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            logic       b, c, m;
            logic [7:0] qq;
            exp_t       e;
            b  = (k == 0) ? busy0 : busy1;
            c  = (k == 0) ? ck0 : ck1;
            m  = (k == 0) ? mosi0 : mosi1;
            qq = (k == 0) ? q0 : q1;
            if (reset) begin
                cnt_busy[k] = 0; nrise[k] = 0; viol[k] = 0; msh[k] = 8'h00;
                pb[k] = 1'b0; pck[k] = 1'b0; pmosi[k] = 1'b1;
            end else begin
                if (b) cnt_busy[k]++;
                if (c && !pck[k]) begin
                    nrise[k]++;
                    msh[k] = {msh[k][6:0], m};
                end
                if (c && pck[k] && (m != pmosi[k])) viol[k]++;
                if (!b && pb[k]) begin
                    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                        check($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
                    end else begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        check($sformatf("q%0d", k), {24'd0, qq}, {24'd0, e.q});
                        check($sformatf("mosi_bits%0d", k), {24'd0, msh[k]}, {24'd0, e.mosi});
                        check($sformatf("rise_cnt%0d", k), nrise[k], 8);
                        check($sformatf("busy_cycles%0d", k), cnt_busy[k], e.cycles);
                        check($sformatf("mosi_while_ck_hi%0d", k), viol[k], 0);
                        check($sformatf("idle_ck%0d", k), {31'd0, c}, 32'd0);
                        check($sformatf("idle_mosi%0d", k), {31'd0, m}, 32'd1);
                    end
                    cnt_busy[k] = 0; nrise[k] = 0; viol[k] = 0; msh[k] = 8'h00;
                end
                pb[k] = b; pck[k] = c; pmosi[k] = m;
            end
        end
    end

    // One-cycle strobe, driven between clock edges
    task automatic strobe(input int k, input logic tx, input logic rx, input logic cs,
                          input logic [7:0] dv);
        @(negedge clock);
        d   = dv;
        csW = cs;
        if (k == 0) begin txW0 = tx; rxR0 = rx; end
        else        begin txW1 = tx; rxR1 = rx; end
        @(negedge clock);
        csW = 1'b0; txW0 = 1'b0; rxR0 = 1'b0; txW1 = 1'b0; rxR1 = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (((k == 0) ? busy0 : busy1) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check($sformatf("timeout%0d", k), 32'd1, 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic push0(input logic [7:0] eq, input logic [7:0] em);
        exp_t e;
        e.q = eq; e.mosi = em; e.cycles = 32;
        sb0.push_back(e);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_cs", {31'd0, cs0}, 32'd1);
        check("rst_ck", {31'd0, ck0}, 32'd0);
        check("rst_mosi", {31'd0, mosi0}, 32'd1);
        check("rst_q", {24'd0, q0}, 32'hFF);
        check("rst_busy", {31'd0, busy0}, 32'd0);

        // Loopback transmit A5
        loop0 = 1'b1;
        strobe(0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("cs_low", {31'd0, cs0}, 32'd0);
        push0(8'hA5, 8'hA5);
        strobe(0, 1'b1, 1'b0, 1'b0, 8'hA5);
        check("busy_after_start", {31'd0, busy0}, 32'd1);
        wait_idle(0);

        // Read-triggered exchange with MISO low
        loop0 = 1'b0; miso_val = 1'b0;
        push0(8'h00, 8'hFF);
        strobe(0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle(0);
        check("cs_unchanged", {31'd0, cs0}, 32'd0);

        // txW while busy is dropped
        loop0 = 1'b1;
        push0(8'hC3, 8'hC3);
        strobe(0, 1'b1, 1'b0, 1'b0, 8'hC3);
        repeat (8) @(negedge clock);
        strobe(0, 1'b1, 1'b0, 1'b0, 8'h3C);
        wait_idle(0);

        // Simultaneous txW and rxR: txW wins
        push0(8'h12, 8'h12);
        strobe(0, 1'b1, 1'b1, 1'b0, 8'h12);
        wait_idle(0);

        // csW mid-transfer only moves chip-select
        push0(8'h5A, 8'h5A);
        strobe(0, 1'b1, 1'b0, 1'b0, 8'h5A);
        repeat (5) @(negedge clock);
        strobe(0, 1'b0, 1'b0, 1'b1, 8'h01);
        check("cs_mid_xfer", {31'd0, cs0}, 32'd1);
        check("busy_mid_cs", {31'd0, busy0}, 32'd1);
        wait_idle(0);

        // DIV=1 loopback
        begin
            exp_t e;
            e.q = 8'hA5; e.mosi = 8'hA5; e.cycles = 16;
            sb1.push_back(e);
        end
        strobe(1, 1'b1, 1'b0, 1'b0, 8'hA5);
        wait_idle(1);

        // Reset after the 4th rising edge aborts without a q update
        strobe(0, 1'b1, 1'b0, 1'b0, 8'h66);
        begin
            int   rises, n;
            logic pc;
            rises = 0; n = 0; pc = ck0;
            while (rises < 4 && n < 200) begin
                @(negedge clock);
                if (ck0 && !pc) rises++;
                pc = ck0;
                n++;
            end
            check("reach_4th_rise", rises, 4);
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_cs", {31'd0, cs0}, 32'd1);
        check("abort_ck", {31'd0, ck0}, 32'd0);
        check("abort_mosi", {31'd0, mosi0}, 32'd1);
        check("abort_q", {24'd0, q0}, 32'hFF);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("post_abort_busy", {31'd0, busy0}, 32'd0);

        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
